// File: rtl/riv_mem_port_arbiter.sv
// Shares the core's single memory port between instruction fetch (IF) and the
// MEM-stage data access, with one outstanding transaction at a time.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   if_req/if_addr/if_flush         fetch request, address, branch-redirect discard
//   if_rvalid/if_rdata              fetch response (1-cycle pulse, data passed through)
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata  data request from the pipeline mem_* fields
//   dm_rvalid/dm_rdata              load data / store acknowledge
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  port request, held until mem_gnt
//   mem_gnt/mem_rvalid/mem_rdata    port accept and response
//   stall_if/stall_mem              pipeline stall terms (combinational)
module riv_mem_port_arbiter #(
    parameter int unsigned ADDR_W     = 64,
    parameter int unsigned DATA_W     = 64,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  if_req,
    input  logic [ADDR_W-1:0]     if_addr,
    input  logic                  if_flush,
    output logic                  if_rvalid,
    output logic [DATA_W-1:0]     if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [DATA_W/8-1:0]   dm_be,
    input  logic [ADDR_W-1:0]     dm_addr,
    input  logic [DATA_W-1:0]     dm_wdata,
    output logic                  dm_rvalid,
    output logic [DATA_W-1:0]     dm_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [DATA_W/8-1:0]   mem_be,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [DATA_W-1:0]     mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic                  stall_if,
    output logic                  stall_mem
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RSP  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                owner_if_q, owner_if_d;
    logic                drop_q, drop_d;
    logic [CNT_W-1:0]    starve_q, starve_d;
    logic                we_q, we_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    logic data_wins;
    logic rsp_fire;

    // Data has priority unless a pending fetch has been passed over STARVE_MAX times.
    assign data_wins = dm_req && !(if_req && (starve_q == STARVE_LIM));
    assign rsp_fire  = (state_q == ST_RSP) && mem_rvalid;

    // Next-state, arbitration and flush bookkeeping.
    always_comb begin
        state_d    = state_q;
        owner_if_d = owner_if_q;
        drop_d     = drop_q;
        starve_d   = starve_q;
        we_d       = we_q;
        be_d       = be_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            ST_IDLE: begin
                if (data_wins) begin
                    state_d    = ST_REQ;
                    owner_if_d = 1'b0;
                    drop_d     = 1'b0;
                    we_d       = dm_we;
                    be_d       = dm_be;
                    addr_d     = dm_addr;
                    wdata_d    = dm_wdata;
                    if (if_req) begin
                        starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + CNT_W'(1);
                    end else begin
                        starve_d = '0;
                    end
                end else if (if_req) begin
                    state_d    = ST_REQ;
                    owner_if_d = 1'b1;
                    drop_d     = 1'b0;
                    we_d       = 1'b0;
                    be_d       = '1;
                    addr_d     = if_addr;
                    wdata_d    = '0;
                    starve_d   = '0;
                end
            end
            ST_REQ: begin
                if (owner_if_q && if_flush) begin
                    drop_d = 1'b1;
                end
                if (mem_gnt) begin
                    state_d = ST_RSP;
                end
            end
            ST_RSP: begin
                if (mem_rvalid) begin
                    state_d = ST_IDLE;
                    drop_d  = 1'b0;
                end else if (owner_if_q && if_flush) begin
                    drop_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and request-field registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            owner_if_q <= 1'b0;
            drop_q     <= 1'b0;
            starve_q   <= '0;
            we_q       <= 1'b0;
            be_q       <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            owner_if_q <= owner_if_d;
            drop_q     <= drop_d;
            starve_q   <= starve_d;
            we_q       <= we_d;
            be_q       <= be_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    assign mem_req   = (state_q == ST_REQ);
    assign mem_we    = we_q;
    assign mem_be    = be_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    // A fetch response is swallowed if a redirect arrived before or with it.
    assign if_rvalid = rsp_fire && owner_if_q && !drop_q && !if_flush;
    assign dm_rvalid = rsp_fire && !owner_if_q;
    assign if_rdata  = if_rvalid ? mem_rdata : '0;
    assign dm_rdata  = dm_rvalid ? mem_rdata : '0;

    assign stall_if  = if_req && !if_rvalid;
    assign stall_mem = dm_req && !dm_rvalid;

`ifndef SYNTHESIS
    // The port may only respond while a granted request is outstanding.
    a_rvalid_in_rsp: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rvalid |-> (state_q == ST_RSP));
`endif

endmodule

// File: tb/tb_riv_mem_port_arbiter.sv
// Self-checking bench for riv_mem_port_arbiter: transaction-level reference
// model compared every cycle, a memory responder, directed scenarios with
// literal expectations, then a randomized phase.
module tb_riv_mem_port_arbiter;

    localparam int STARVE_MAX = 4;

    logic        clk;
    logic        rst_n;
    logic        if_req, if_flush, if_rvalid;
    logic [63:0] if_addr, if_rdata;
    logic        dm_req, dm_we, dm_rvalid;
    logic [7:0]  dm_be;
    logic [63:0] dm_addr, dm_wdata, dm_rdata;
    logic        mem_req, mem_we, mem_gnt, mem_rvalid;
    logic [7:0]  mem_be;
    logic [63:0] mem_addr, mem_wdata, mem_rdata;
    logic        stall_if, stall_mem;

    riv_mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .stall_if(stall_if), .stall_mem(stall_mem)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int checks = 0;
    int failures = 0;

    // Observation counters and grant log, written only by the checker.
    int cyc = 0;
    int if_rv_cnt = 0, dm_rv_cnt = 0, port_rsp_cnt = 0, if_rv_cyc = 0;
    int stall_mem_cyc = 0, gnt_wait_cyc = 0;
    logic [63:0] g_addr[$];
    logic [63:0] g_wdata[$];
    logic [7:0]  g_be[$];
    logic        g_we[$];

    // Reference model of the single outstanding transaction.
    bit          m_busy, m_granted, m_own_if, m_drop;
    int          m_starve;
    logic        m_we;
    logic [7:0]  m_be;
    logic [63:0] m_addr, m_wdata;

    // Memory responder configuration.
    int gnt_cfg = 0, rsp_cfg = 1;
    bit mem_rand = 0;
    logic [63:0] ref_mem [logic [63:0]];

    // Requester bookkeeping, written only by the main process.
    int if_seen = 0, dm_seen = 0, if_age = 0, dm_age = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic bail(input string nm);
        checks++;
        failures++;
        $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    function automatic logic [63:0] rd(input logic [63:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return {~a[31:0], a[31:0] ^ 32'h5A5A5A5A};
    endfunction

    // Memory port: grants after a delay, responds 1+ cycles after the grant.
    initial begin
        bit          seen_req, rpend;
        int          gcnt, rcnt;
        logic [63:0] rdata_q, w;
        seen_req = 0; rpend = 0; gcnt = 0; rcnt = 0; rdata_q = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            mem_rdata  = {$urandom, $urandom};
            if (!rst_n) begin
                seen_req = 0;
                rpend    = 0;
            end else begin
                if (rpend) begin
                    if (rcnt == 0) begin
                        mem_rvalid = 1'b1;
                        mem_rdata  = rdata_q;
                        rpend      = 0;
                    end else begin
                        rcnt--;
                    end
                end
                if (mem_req) begin
                    if (!seen_req) begin
                        seen_req = 1;
                        gcnt = mem_rand ? int'($urandom_range(0, 3)) : gnt_cfg;
                    end
                    if (gcnt == 0) begin
                        mem_gnt  = 1'b1;
                        seen_req = 0;
                        rpend    = 1;
                        rcnt     = (mem_rand ? int'($urandom_range(1, 3)) : rsp_cfg) - 1;
                        rdata_q  = rd(mem_addr);
                        if (mem_we) begin
                            w = rd(mem_addr);
                            for (int b = 0; b < 8; b++)
                                if (mem_be[b]) w[b*8 +: 8] = mem_wdata[b*8 +: 8];
                            ref_mem[mem_addr] = w;
                        end
                    end else begin
                        gcnt--;
                    end
                end
            end
        end
    end

    // Per-cycle compare against the model, then advance the model.
    initial begin
        bit exp_req, exp_fire, exp_if_rv, exp_dm_rv;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                m_busy = 0; m_granted = 0; m_drop = 0; m_starve = 0;
                chk("rst_mem_req",   64'(mem_req),   64'd0);
                chk("rst_if_rvalid", 64'(if_rvalid), 64'd0);
                chk("rst_dm_rvalid", 64'(dm_rvalid), 64'd0);
                chk("rst_mem_addr",  mem_addr,       64'd0);
                chk("rst_mem_be",    64'(mem_be),    64'd0);
                chk("rst_if_rdata",  if_rdata,       64'd0);
                chk("rst_stall_if",  64'(stall_if),  64'(if_req));
                chk("rst_stall_mem", 64'(stall_mem), 64'(dm_req));
            end else begin
                exp_req   = m_busy && !m_granted;
                exp_fire  = m_busy && m_granted && mem_rvalid;
                exp_if_rv = exp_fire && m_own_if && !m_drop && !if_flush;
                exp_dm_rv = exp_fire && !m_own_if;
                chk("mem_req",   64'(mem_req),   64'(exp_req));
                chk("if_rvalid", 64'(if_rvalid), 64'(exp_if_rv));
                chk("dm_rvalid", 64'(dm_rvalid), 64'(exp_dm_rv));
                chk("stall_if",  64'(stall_if),  64'(if_req && !exp_if_rv));
                chk("stall_mem", 64'(stall_mem), 64'(dm_req && !exp_dm_rv));
                if (exp_req) begin
                    chk("mem_addr", mem_addr,    m_addr);
                    chk("mem_we",   64'(mem_we), 64'(m_we));
                    chk("mem_be",   64'(mem_be), 64'(m_be));
                    if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
                end
                if (exp_if_rv) chk("if_rdata", if_rdata, mem_rdata);
                if (exp_dm_rv) chk("dm_rdata", dm_rdata, mem_rdata);

                if (if_rvalid) begin if_rv_cnt++; if_rv_cyc = cyc; end
                if (dm_rvalid) dm_rv_cnt++;
                if (mem_rvalid) port_rsp_cnt++;
                if (stall_mem) stall_mem_cyc++;
                if (mem_req && !mem_gnt) gnt_wait_cyc++;
                if (mem_req && mem_gnt) begin
                    g_addr.push_back(mem_addr);
                    g_we.push_back(mem_we);
                    g_be.push_back(mem_be);
                    g_wdata.push_back(mem_wdata);
                end

                if (!m_busy) begin
                    if (dm_req && !(if_req && m_starve == STARVE_MAX)) begin
                        m_busy = 1; m_granted = 0; m_own_if = 0; m_drop = 0;
                        m_addr = dm_addr; m_we = dm_we; m_be = dm_be; m_wdata = dm_wdata;
                        m_starve = if_req ? ((m_starve < STARVE_MAX) ? m_starve + 1 : STARVE_MAX) : 0;
                    end else if (if_req) begin
                        m_busy = 1; m_granted = 0; m_own_if = 1; m_drop = 0;
                        m_addr = if_addr; m_we = 1'b0; m_be = 8'hFF; m_wdata = '0;
                        m_starve = 0;
                    end
                end else if (!m_granted) begin
                    if (m_own_if && if_flush) m_drop = 1;
                    if (mem_gnt) m_granted = 1;
                end else begin
                    if (mem_rvalid) begin
                        m_busy = 0;
                        m_drop = 0;
                    end else if (m_own_if && if_flush) begin
                        m_drop = 1;
                    end
                end
            end
        end
    end

    // One requester cycle: drop after a response, maybe raise/flush (percent chances).
    task automatic tick(input int p_if, input int p_dm, input int p_fl);
        @(posedge clk);
        #1;
        if_flush = 1'b0;
        if (if_rv_cnt != if_seen) begin if_seen = if_rv_cnt; if_req = 1'b0; end
        if (dm_rv_cnt != dm_seen) begin dm_seen = dm_rv_cnt; dm_req = 1'b0; end
        if (!if_req) begin
            if (int'($urandom_range(0, 99)) < p_if) begin
                if_req = 1'b1; if_age = 0;
                if_addr = 64'h10000 + 64'($urandom & 32'hFFF8);
            end
        end else begin
            if_age++;
            if (int'($urandom_range(0, 99)) < p_fl) begin
                if_flush = 1'b1;
                if_addr = 64'h10000 + 64'($urandom & 32'hFFF8);
            end
        end
        if (!dm_req) begin
            if (int'($urandom_range(0, 99)) < p_dm) begin
                dm_req = 1'b1; dm_age = 0;
                dm_we = 1'($urandom);
                dm_be = 8'($urandom);
                dm_addr = 64'h80000 + 64'($urandom & 32'hFFF8);
                dm_wdata = {$urandom, $urandom};
            end
        end else begin
            dm_age++;
        end
        if (if_age > 500) bail("if_wait");
        if (dm_age > 500) bail("dm_wait");
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (if_req || dm_req); i++) tick(0, 0, 0);
        if (if_req || dm_req) bail("drain");
    endtask

    initial begin
        int base, rv0, dv0, pr0, sw0, gw0, req_cyc;
        logic [9:0] pat;
        rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_flush = 1'b0;
        dm_req = 1'b0; dm_we = 1'b0; dm_be = '0; dm_addr = '0; dm_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_mem_req",  64'(mem_req),  64'd0);
        chk("reset_mem_we",   64'(mem_we),   64'd0);
        chk("reset_dm_rdata", dm_rdata,      64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Lone fetch, grant same cycle, response one cycle later.
        gnt_cfg = 0; rsp_cfg = 1;
        base = g_addr.size(); rv0 = if_rv_cnt;
        if_req = 1'b1; if_addr = 64'h1000; if_age = 0; req_cyc = cyc + 1;
        drain();
        chk("fetch_grants", 64'(g_addr.size() - base), 64'd1);
        if (g_addr.size() > base) begin
            chk("fetch_addr", g_addr[base],        64'h1000);
            chk("fetch_be",   64'(g_be[base]),     64'hFF);
            chk("fetch_we",   64'(g_we[base]),     64'd0);
        end
        chk("fetch_latency", 64'(if_rv_cyc - req_cyc), 64'd2);
        chk("fetch_rvalids", 64'(if_rv_cnt - rv0),     64'd1);

        // Simultaneous store and fetch: store goes first.
        base = g_addr.size(); rv0 = if_rv_cnt; dv0 = dm_rv_cnt;
        if_req = 1'b1; if_addr = 64'h1008; if_age = 0;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 8'h0F; dm_addr = 64'h2000;
        dm_wdata = 64'hDEADBEEF; dm_age = 0;
        drain();
        chk("simul_grants", 64'(g_addr.size() - base), 64'd2);
        if (g_addr.size() > base + 1) begin
            chk("simul_first_we",    64'(g_we[base]),   64'd1);
            chk("simul_first_addr",  g_addr[base],      64'h2000);
            chk("simul_first_be",    64'(g_be[base]),   64'h0F);
            chk("simul_first_wdata", g_wdata[base],     64'hDEADBEEF);
            chk("simul_second_addr", g_addr[base + 1],  64'h1008);
            chk("simul_second_we",   64'(g_we[base + 1]), 64'd0);
        end
        chk("simul_dm_rvalids", 64'(dm_rv_cnt - dv0), 64'd1);
        chk("simul_if_rvalids", 64'(if_rv_cnt - rv0), 64'd1);

        // Both sides requesting continuously: four data grants, then fetch, repeating.
        base = g_addr.size();
        for (int i = 0; i < 300 && (g_addr.size() - base) < 10; i++) tick(100, 100, 0);
        drain();
        chk("starve_grant_count", 64'(g_addr.size() - base >= 10), 64'd1);
        pat = '0;
        if (g_addr.size() - base >= 10)
            for (int i = 0; i < 10; i++) pat = {pat[8:0], g_addr[base + i] < 64'h80000};
        chk("starve_order", 64'(pat), 64'(10'b0000100001));

        // Redirect during the response phase of fetch 0x3000.
        gnt_cfg = 0; rsp_cfg = 3;
        base = g_addr.size(); rv0 = if_rv_cnt; pr0 = port_rsp_cnt;
        if_req = 1'b1; if_addr = 64'h3000; if_age = 0;
        tick(0, 0, 0);
        @(posedge clk);
        #1;
        if_flush = 1'b1; if_addr = 64'h4000;
        drain();
        chk("flush_grants", 64'(g_addr.size() - base), 64'd2);
        if (g_addr.size() > base + 1) begin
            chk("flush_old_addr", g_addr[base],     64'h3000);
            chk("flush_new_addr", g_addr[base + 1], 64'h4000);
        end
        chk("flush_if_rvalids", 64'(if_rv_cnt - rv0),    64'd1);
        chk("flush_port_rsps",  64'(port_rsp_cnt - pr0), 64'd2);

        // Grant withheld for five cycles on a store.
        gnt_cfg = 5; rsp_cfg = 1;
        sw0 = stall_mem_cyc; gw0 = gnt_wait_cyc;
        dm_req = 1'b1; dm_we = 1'b1; dm_be = 8'hFF; dm_addr = 64'h5000;
        dm_wdata = 64'h0123456789ABCDEF; dm_age = 0;
        drain();
        chk("gnt_wait_cycles",  64'(gnt_wait_cyc - gw0),  64'd5);
        chk("stall_mem_cycles", 64'(stall_mem_cyc - sw0), 64'd7);

        // Reset asserted mid-response, then a fresh fetch.
        gnt_cfg = 0; rsp_cfg = 4;
        rv0 = if_rv_cnt;
        if_req = 1'b1; if_addr = 64'h6000; if_age = 0;
        tick(0, 0, 0);
        tick(0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_mem_req",   64'(mem_req),   64'd0);
        chk("midrst_mem_addr",  mem_addr,       64'd0);
        chk("midrst_mem_be",    64'(mem_be),    64'd0);
        chk("midrst_if_rvalid", 64'(if_rvalid), 64'd0);
        chk("midrst_stall_if",  64'(stall_if),  64'd1);
        if_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        gnt_cfg = 0; rsp_cfg = 1;
        if_req = 1'b1; if_addr = 64'h7000; if_age = 0;
        drain();
        chk("postrst_if_rvalids", 64'(if_rv_cnt - rv0), 64'd1);
        chk("postrst_addr", g_addr[g_addr.size() - 1], 64'h7000);

        // Randomized traffic with random port timing and redirects.
        mem_rand = 1;
        rv0 = if_rv_cnt; dv0 = dm_rv_cnt;
        for (int i = 0; i < 4000; i++) tick(35, 35, 6);
        drain();
        chk("random_if_activity", 64'(if_rv_cnt - rv0 > 50), 64'd1);
        chk("random_dm_activity", 64'(dm_rv_cnt - dv0 > 50), 64'd1);

        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        bail("global_timeout");
    end

endmodule
